// File: rtl/fifo_axis_reader.sv
// Drains a synchronous FIFO into an AXI4-Stream master with tlast every BURST_LEN beats; optional FIFO_AXIS_READER_STATS_EN adds beat/stall counters.
// Latency: 2 cycles from the first fifo_rd_en to tvalid, then 1 beat/cycle.
// Backpressure: 3-entry skid buffer absorbs tready stalls; reads stop when buffer + inflight reach 3.
module fifo_axis_reader #(
  parameter int WIDTH     = 128,
  parameter int BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic             fifo_wr_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tlast
`ifdef FIFO_AXIS_READER_STATS_EN
  ,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_stall
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]       occ;
  logic [1:0]       head;
  logic [1:0]       tail;
  logic             inflight;
  logic [CNT_W-1:0] beat_cnt;
  logic [WIDTH-1:0] buffer [0:2];
  logic             xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserving space for the inflight beat keeps occupancy within 3 without looking at tready.
  assign fifo_rd_en = !rst && en && !fifo_empty && !fifo_wr_en &&
                      (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = buffer[head];
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_BEAT);
  assign xfer          = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      head     <= 2'd0;
      tail     <= 2'd0;
      inflight <= 1'b0;
      beat_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + {1'b0, inflight} - {1'b0, xfer};
      if (inflight) begin
        buffer[tail] <= fifo_rd_data;
        tail         <= ptr_inc(tail);
      end
      if (xfer) begin
        head     <= ptr_inc(head);
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

`ifdef FIFO_AXIS_READER_STATS_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if (xfer && (stat_beats != 32'hFFFF_FFFF)) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if (m_axis_tvalid && !m_axis_tready && (stat_stall != 32'hFFFF_FFFF)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench: a queue-based FIFO model feeds the reader; a negedge monitor checks order, tlast framing and AXI hold rules.
module tb_fifo_axis_reader;
  localparam int WIDTH = 32;
  localparam int BL    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             fifo_empty = 1'b1;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_rd_en;
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tlast;
`ifdef FIFO_AXIS_READER_STATS_EN
  logic [31:0]      stat_beats;
  logic [31:0]      stat_stall;
`endif

  fifo_axis_reader #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast)
`ifdef FIFO_AXIS_READER_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_stall    (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  beat_t            exp_q[$];
  logic [WIDTH-1:0] fq[$];
  int               wr_cnt = 0;
  int               tests = 0;
  int               fails = 0;
  int               n_xfer = 0;
  int               n_last = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // FIFO model: read data appears the cycle after the read; every write queues the expected beat.
  always @(posedge clk) begin
    beat_t b;
    if (fifo_rd_en) begin
      check("rd_during_wr", fifo_wr_en, 0);
      check("rd_underflow", fq.size() == 0, 0);
      if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
    end
    if (fifo_wr_en) begin
      fq.push_back(wr_data);
      b.d = wr_data;
      b.l = (wr_cnt % BL) == (BL - 1);
      exp_q.push_back(b);
      wr_cnt++;
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_d;
  logic             prev_l;
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tvalid, 1);
        check("hold_data", tdata, prev_d);
        check("hold_last", tlast, prev_l);
      end
      if (!tvalid) check("last_wo_valid", tlast, 0);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("data", tdata, b.d);
          check("last", tlast, b.l);
        end
        n_xfer++;
        if (tlast) n_last++;
      end
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_l     = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_wr_en = 1'b1;
      wr_data    = base + WIDTH'(i);
      tick();
    end
    fifo_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    wr_cnt     = 0;
    fifo_wr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    en     = 1'b1;
    tready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && fq.size() == 0 && !tvalid) break;
      tick();
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int first_rd, first_v, rd_n, rd_last, v_n, v_last, base_last, xf, cyc;
    logic [WIDTH-1:0] word0;
    rst = 1'b1; en = 1'b0; tready = 1'b0; fifo_wr_en = 1'b0; wr_data = '0;
    #2;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    // Word written while in reset: rd_en must stay low despite a non-empty FIFO.
    fifo_wr_en = 1'b1; wr_data = 32'hA5; tick();
    fifo_wr_en = 1'b0; en = 1'b1; tick();
    check("rst_fifo_nonempty", fifo_empty, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0; tready = 1'b1;
    drain();

    // 1: latency and back-to-back delivery
    do_reset();
    en = 1'b0; tready = 1'b1;
    write_words(4, 32'h1);
    en = 1'b1;
    first_rd = -1; first_v = -1; rd_n = 0; rd_last = -1; v_n = 0; v_last = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin if (first_rd < 0) first_rd = i; rd_n++; rd_last = i; end
      if (tvalid)     begin if (first_v < 0) first_v = i;  v_n++;  v_last = i; end
    end
    #1;
    check("t1_first_rd", first_rd, 0);
    check("t1_rd_count", rd_n, 4);
    check("t1_rd_last", rd_last, 3);
    check("t1_latency", first_v - first_rd, 2);
    check("t1_valid_count", v_n, 4);
    check("t1_valid_last", v_last, 5);
    tick();
    drain();

    // 2: framing over three bursts
    do_reset();
    base_last = n_last;
    write_words(12, 32'h100);
    drain();
    check("t2_tlast_count", n_last - base_last, 3);

    // 3: long stall
    do_reset();
    tready = 1'b0; en = 1'b0;
    write_words(10, 32'h200);
    word0 = 32'h200;
    en = 1'b1;
    rd_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_n++;
    end
    check("t3_stall_reads", rd_n, 3);
    check("t3_stall_valid", tvalid, 1);
    check("t3_stall_data", tdata, word0);
    @(posedge clk); #1;
    tready = 1'b1;
    xf = 0; cyc = 0;
    for (int i = 0; i < 40 && xf < 10; i++) begin
      @(negedge clk);
      if (tvalid && tready) xf++;
      if (xf > 0) cyc++;
    end
    check("t3_beats", xf, 10);
    check("t3_no_gaps", cyc, 10);
    @(posedge clk); #1;
    drain();

    // 4: reader yields to the writer
    do_reset();
    en = 1'b1; tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fifo_wr_en = 1'b1;
      wr_data    = 32'h300 + WIDTH'(i);
      @(negedge clk);
      check("t4_rd_yield", fifo_rd_en, 0);
      @(posedge clk); #1;
    end
    fifo_wr_en = 1'b0;
    @(negedge clk);
    check("t4_rd_after_wr", fifo_rd_en, 1);
    @(posedge clk); #1;
    drain();

    // 5: reset mid-frame with two beats buffered
    do_reset();
    en = 1'b1; tready = 1'b1;
    write_words(2, 32'h400);
    drain();
    tready = 1'b0;
    write_words(2, 32'h410);
    for (int i = 0; i < 6; i++) tick();
    check("t5_pre_valid", tvalid, 1);
    #2;
    rst = 1'b1;
    fq.delete(); exp_q.delete(); wr_cnt = 0;
    #1;
    check("t5_async_tvalid", tvalid, 0);
    check("t5_async_tdata", tdata, 0);
    check("t5_async_tlast", tlast, 0);
    @(posedge clk); #1;
    fifo_wr_en = 1'b1; wr_data = 32'h4F0; tick();
    fifo_wr_en = 1'b0;
    @(negedge clk);
    check("t5_rd_en_in_rst", fifo_rd_en, 0);
    @(posedge clk); #1;
    rst = 1'b0; tready = 1'b1;
    base_last = n_last;
    write_words(7, 32'h420);
    drain();
    check("t5_tlast_count", n_last - base_last, 2);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      fifo_wr_en = ($urandom_range(0, 2) != 0) && (fq.size() < 32);
      wr_data    = $urandom;
      en         = $urandom_range(0, 3) != 0;
      tready     = $urandom_range(0, 2) != 0;
      tick();
    end
    fifo_wr_en = 1'b0;
    drain();

`ifdef FIFO_AXIS_READER_STATS_EN
    // 6: statistics counters
    do_reset();
    check("t6_rst_beats", stat_beats, 0);
    check("t6_rst_stall", stat_stall, 0);
    en = 1'b0; tready = 1'b0;
    write_words(5, 32'h500);
    en = 1'b1;
    for (int i = 0; i < 10 && !tvalid; i++) @(negedge clk);
    check("t6_valid_seen", tvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    tready = 1'b1;
    drain();
    check("t6_stat_beats", stat_beats, 5);
    check("t6_stat_stall", stat_stall, 3);
`endif

    check("final_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
- Read-side drain stage placed directly downstream of the team's synchronous FIFO.
- Drives the FIFO rd_en and captures rd_data, which arrives one cycle after the read.
- Presents the data as an AXI4-Stream master with full backpressure support and tlast framing every BURST_LEN beats.
- A 3-entry output buffer sustains 1 beat/cycle with no combinational path from m_axis_tready to fifo_rd_en.

Parameters:
- WIDTH, 128: data width; must match the FIFO WIDTH.
- BURST_LEN, 16: beats per frame; tlast is asserted on the last beat. Legal range is BURST_LEN >= 1.
- CNT_W (localparam), $clog2(BURST_LEN)+1: beat counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  permits new FIFO reads; buffered beats still drain when low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_wr_en  in  1  FIFO write-enable monitor; the FIFO ignores a read issued in the same cycle as a write.
- fifo_rd_data  in  WIDTH  FIFO read data, valid the cycle after an accepted read.
- fifo_rd_en  out  1  FIFO read request.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  WIDTH  stream data.
- m_axis_tlast  out  1  end of frame.

Behaviour:
Reset (asynchronous on rst high):
- Clears occupancy (occ), inflight, head/tail pointers and beat_cnt.
- Outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- fifo_rd_en is forced 0 while rst is high.

Read issue (combinational from registered state only):
- fifo_rd_en = en & !fifo_empty & !fifo_wr_en & (occ + inflight < 3).
- inflight <= fifo_rd_en each cycle.
- The fifo_wr_en gate makes the reader yield to the writer, because the FIFO drops simultaneous read+write. Every issued read is therefore accepted.

Capture:
- When inflight=1, fifo_rd_data is written to buffer[tail] and tail advances mod 3.

Output:
- m_axis_tvalid = (occ != 0).
- m_axis_tdata = buffer[head].
- m_axis_tlast = tvalid & (beat_cnt == BURST_LEN-1).
- xfer = tvalid & tready. On xfer, head advances mod 3.
- occ_next = occ + inflight - xfer; occ range is 0..3 and never overflows.

AXI rules:
- Once tvalid is high, tvalid, tdata and tlast stay stable until xfer.
- tvalid never depends on tready.

Beat counter:
- Increments on xfer.
- On an xfer with beat_cnt == BURST_LEN-1 it wraps to 0.
- BURST_LEN=1 gives tlast on every beat.

Timing:
- Latency is 2 cycles from the first fifo_rd_en to tvalid (read cycle, then capture cycle; tvalid is high in the cycle after capture).
- Steady-state throughput is 1 beat/cycle while tready=1 and the FIFO is non-empty.

Boundary cases:
- fifo_empty mid-stream: no read is issued; buffered beats drain normally.
- en deasserted: no new reads; an inflight beat is still captured; all beats still drain.
- tready low for N cycles: occ reaches 3 and reads stop. No data is lost or duplicated.
- Simultaneous capture and xfer with occ=3 cannot occur, because inflight=0 whenever occ=3.
- Reset mid-frame: buffered and inflight beats are discarded. beat_cnt restarts at 0, so the next frame starts fresh.

Optional Feature:
Macro FIFO_AXIS_READER_STATS_EN.
- Defined:
  - Adds ports stat_beats out 32 and stat_stall out 32. Both reset to 0.
  - stat_beats increments on each xfer.
  - stat_stall increments on each cycle with tvalid & !tready.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent. Core behaviour is identical in both builds.

Test Plan:
1. Reset release, FIFO preloaded with 4 words 0x1..0x4, tready=1 -> fifo_rd_en high 4 consecutive cycles; tvalid from cycle 2 after first read; tdata 0x1,0x2,0x3,0x4 on consecutive cycles; tlast=0 (BURST_LEN=16).
2. BURST_LEN=4, 8 words, tready=1 -> tlast high on the 4th and 8th beats only; beat_cnt back to 0.
3. 10 words, tready held 0 for 20 cycles then 1 -> exactly 3 reads issued during the stall, tvalid and tdata=word0 stable throughout; then all 10 words delivered in order with no gaps beyond FIFO latency.
4. fifo_wr_en=1 in the cycle a read would issue (fifo_empty=0) -> fifo_rd_en=0 that cycle; read issues the next cycle; no word lost or duplicated across 6 words.
5. rst pulsed high mid-frame with occ=2 -> tvalid=0, tlast=0, tdata=0 immediately (async); after release the next frame's tlast comes after BURST_LEN beats.
6. With FIFO_AXIS_READER_STATS_EN, 5 beats with 3 tready-low stall cycles -> stat_beats=5, stat_stall=3.
